// File: rtl/downscale_block.sv
// Softmax downscale: buffers N FP32 samples, tracks the max, replays x_i - max.
// Optional `DOWNSCALE_MAX_OUT_EN adds downscale_max_o / downscale_max_valid_o.
module downscale_block #(
    parameter int N      = 10,
    parameter int ADDR_W = 4
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [31:0] downscale_data_i,
    input  logic        downscale_data_valid_i,
    output logic        downscale_ready_o,
    output logic [31:0] downscale_data_o,
    output logic        downscale_data_valid_o,
`ifdef DOWNSCALE_MAX_OUT_EN
    output logic [31:0] downscale_max_o,
    output logic        downscale_max_valid_o,
`endif
    output logic        downscale_done_o
);

    typedef enum logic {COLLECT, EMIT} state_t;

    localparam logic [31:0]       NEG_INF = 32'hFF80_0000;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);

    // Sign-magnitude order with +0 == -0
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic az, bz;
        az = (a[30:0] == 31'd0);
        bz = (b[30:0] == 31'd0);
        if (az && bz)
            return 1'b0;
        if (a[31] != b[31])
            return b[31];
        if (!a[31])
            return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (v[i])
                n = 5'(23 - i);
        return n;
    endfunction

    state_t state_q, state_d;

    logic [31:0]       mem [N];
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_busy;
    logic [31:0]       max_q, max_nxt;
    logic              accept, last_in;

    logic        rd_v, rd_last;
    logic [31:0] rd_x;

    logic        s1_v, s1_last, s1_sign, s1_sub;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mb, s1_ms;

    assign accept  = downscale_data_valid_i && (state_q == COLLECT);
    assign last_in = accept && (wr_cnt == LAST);
    assign max_nxt = (accept && fp_gt(downscale_data_i, max_q))
                   ? downscale_data_i : max_q;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i)
            state_q <= COLLECT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (last_in) state_d = EMIT;
            EMIT:    if (downscale_done_o) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        downscale_ready_o = (state_q == COLLECT);
    end

    always_ff @(posedge clock_i) begin
        if (accept)
            mem[wr_cnt] <= downscale_data_i;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_busy <= 1'b0;
            max_q   <= NEG_INF;
            rd_v    <= 1'b0;
            rd_last <= 1'b0;
            rd_x    <= '0;
        end else begin
            if (state_q == COLLECT) begin
                if (accept) begin
                    wr_cnt <= last_in ? '0 : wr_cnt + 1'b1;
                    max_q  <= max_nxt;
                end
                if (last_in) begin
                    rd_busy <= 1'b1;
                    rd_cnt  <= '0;
                end
            end else if (downscale_done_o) begin
                max_q <= NEG_INF;
            end
            rd_v <= rd_busy;
            if (rd_busy) begin
                rd_x    <= mem[rd_cnt];
                rd_last <= (rd_cnt == LAST);
                rd_cnt  <= rd_cnt + 1'b1;
                if (rd_cnt == LAST)
                    rd_busy <= 1'b0;
            end
        end
    end

    // Stage 1: x + (-max), order by magnitude, align the smaller operand
    logic [31:0] q_op;
    logic [7:0]  pe, qe, be, se, diff;
    logic [23:0] pm, qm, bm, sm, sm_sh;
    logic        p_ge, b_sign;

    always_comb begin
        q_op  = {~max_q[31], max_q[30:0]};
        pe    = rd_x[30:23];
        qe    = q_op[30:23];
        pm    = (pe == 8'd0) ? 24'd0 : {1'b1, rd_x[22:0]};
        qm    = (qe == 8'd0) ? 24'd0 : {1'b1, q_op[22:0]};
        p_ge  = {pe, pm} >= {qe, qm};
        be    = p_ge ? pe : qe;
        se    = p_ge ? qe : pe;
        bm    = p_ge ? pm : qm;
        sm    = p_ge ? qm : pm;
        b_sign = p_ge ? rd_x[31] : q_op[31];
        diff  = be - se;
        sm_sh = (diff >= 8'd24) ? 24'd0 : (sm >> diff);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_sign <= 1'b0;
            s1_sub  <= 1'b0;
            s1_exp  <= '0;
            s1_mb   <= '0;
            s1_ms   <= '0;
        end else begin
            s1_v    <= rd_v;
            s1_last <= rd_last;
            s1_sign <= b_sign;
            s1_sub  <= rd_x[31] ^ q_op[31];
            s1_exp  <= be;
            s1_mb   <= bm;
            s1_ms   <= sm_sh;
        end
    end

    // Stage 2: add/sub magnitudes, normalise, flush underflow to +0
    logic [24:0]       sum;
    logic [4:0]        lz;
    logic [22:0]       frac;
    logic signed [9:0] exp10;
    logic [31:0]       res;

    always_comb begin
        sum   = s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms})
                       : ({1'b0, s1_mb} + {1'b0, s1_ms});
        lz    = lzc24(sum[23:0]);
        frac  = 23'(sum[23:0] << lz);
        exp10 = $signed({2'b00, s1_exp}) - $signed({5'd0, lz});
        res   = 32'd0;
        if (sum[24])
            res = {s1_sign, s1_exp + 8'd1, sum[23:1]};
        else if (sum != 25'd0 && exp10 > 10'sd0)
            res = {s1_sign, exp10[7:0], frac};
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            downscale_data_o       <= '0;
            downscale_data_valid_o <= 1'b0;
            downscale_done_o       <= 1'b0;
        end else begin
            if (s1_v)
                downscale_data_o <= res;
            downscale_data_valid_o <= s1_v;
            downscale_done_o       <= s1_v && s1_last;
        end
    end

`ifdef DOWNSCALE_MAX_OUT_EN
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            downscale_max_o       <= '0;
            downscale_max_valid_o <= 1'b0;
        end else begin
            downscale_max_valid_o <= last_in;
            if (last_in)
                downscale_max_o <= max_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_downscale_block.sv
// Directed bench for downscale_block with N=4.
// Max-output checks are compiled in when DOWNSCALE_MAX_OUT_EN is defined.
module tb_downscale_block;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        din_v;
    logic        ready;
    logic [31:0] dout;
    logic        dout_v;
    logic        done;
`ifdef DOWNSCALE_MAX_OUT_EN
    logic [31:0] max_o;
    logic        max_v;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    downscale_block #(.N(4), .ADDR_W(2)) dut (
        .clock_i               (clk),
        .reset_n_i             (rst_n),
        .downscale_data_i      (din),
        .downscale_data_valid_i(din_v),
        .downscale_ready_o     (ready),
        .downscale_data_o      (dout),
        .downscale_data_valid_o(dout_v),
`ifdef DOWNSCALE_MAX_OUT_EN
        .downscale_max_o       (max_o),
        .downscale_max_valid_o (max_v),
`endif
        .downscale_done_o      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input int gap);
        @(negedge clk);
        din_v = 1'b1;
        din   = x;
        @(negedge clk);
        din_v = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Entered on the falling edge right after the last sample was taken
    task automatic expect_vec(input string tag,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3,
                              input logic [31:0] mx, input bit inject);
        logic [31:0] r [4];
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        check({tag, "_ready_lo"}, 32'(ready), 32'd0);
`ifdef DOWNSCALE_MAX_OUT_EN
        check({tag, "_max_v"}, 32'(max_v), 32'd1);
        check({tag, "_max"}, max_o, mx);
`endif
        @(negedge clk);
        check({tag, "_lat1"}, 32'(dout_v), 32'd0);
`ifdef DOWNSCALE_MAX_OUT_EN
        check({tag, "_max_v_pulse"}, 32'(max_v), 32'd0);
`endif
        if (inject) begin
            din_v = 1'b1;
            din   = 32'h4120_0000;
        end
        @(negedge clk);
        din_v = 1'b0;
        check({tag, "_lat2"}, 32'(dout_v), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("%s_v%0d", tag, k), 32'(dout_v), 32'd1);
            check($sformatf("%s_d%0d", tag, k), dout, r[k]);
            check($sformatf("%s_done%0d", tag, k), 32'(done), 32'(k == 3));
        end
        @(negedge clk);
        check({tag, "_end_v"}, 32'(dout_v), 32'd0);
        check({tag, "_end_done"}, 32'(done), 32'd0);
        check({tag, "_end_ready"}, 32'(ready), 32'd1);
        check({tag, "_hold"}, dout, r3);
    endtask

    initial begin
        rst_n = 1'b0;
        din_v = 1'b0;
        din   = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data", dout, 32'd0);
        check("rst_valid", 32'(dout_v), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        send(32'h3F80_0000, 2);
        send(32'h4000_0000, 2);
        send(32'h4040_0000, 2);
        send(32'h3F00_0000, 0);
        expect_vec("pos", 32'hC000_0000, 32'hBF80_0000, 32'h0000_0000,
                   32'hC020_0000, 32'h4040_0000, 1'b0);

        send(32'h3F80_0000, 0);
        send(32'h4000_0000, 1);
        send(32'h4040_0000, 0);
        send(32'h3F00_0000, 0);
        expect_vec("inj", 32'hC000_0000, 32'hBF80_0000, 32'h0000_0000,
                   32'hC020_0000, 32'h4040_0000, 1'b1);

        send(32'hBF80_0000, 0);
        send(32'hC040_0000, 3);
        send(32'hBF80_0000, 0);
        send(32'hC000_0000, 0);
        expect_vec("neg", 32'h0000_0000, 32'hC000_0000, 32'h0000_0000,
                   32'hBF80_0000, 32'hBF80_0000, 1'b0);

        send(32'h4000_0000, 0);
        send(32'h4040_0000, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort_v%0d", i), 32'(dout_v), 32'd0);
        end
        check("abort_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 3; i++)
            send(32'h3F80_0000, 1);
        send(32'h3F80_0000, 0);
        expect_vec("ones", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                   32'h0000_0000, 32'h3F80_0000, 1'b0);

        send(32'h0000_0000, 0);
        send(32'h8000_0000, 0);
        send(32'hBF80_0000, 0);
        send(32'hBF80_0000, 0);
        expect_vec("zero", 32'h0000_0000, 32'h0000_0000, 32'hBF80_0000,
                   32'hBF80_0000, 32'h0000_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
